// File: rtl/axi_bridge_pkg.sv
// Shared definitions for the SRAM-like to AXI bridge: FSM encoding,
// fixed AXI burst/size constants and the write-strobe helper.
package axi_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_A  = 3'd1,
    RD_D  = 3'd2,
    WR_AW = 3'd3,
    WR_B  = 3'd4
  } state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [7:0] LEN_SINGLE = 8'd0;
  localparam logic [1:0] SIZE_BYTE  = 2'd0;
  localparam logic [1:0] SIZE_HALF  = 2'd1;
  localparam logic [1:0] SIZE_WORD  = 2'd2;

  // Byte lanes touched by a transfer of the given size at the given offset.
  // Unaligned halves are not expected; addr[1] alone picks the lane pair.
  function automatic logic [3:0] calc_wstrb(input logic [1:0] size,
                                            input logic [1:0] offs);
    logic [3:0] strb;
    case (size)
      SIZE_BYTE: strb = 4'b0001 << offs;
      SIZE_HALF: strb = offs[1] ? 4'b1100 : 4'b0011;
      default:   strb = 4'b1111;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/sramlike_axi_bridge.sv
// SRAM-like master port to single-beat AXI3 bridge, one transaction in flight.
// Optional build macro DBRIDGE_EARLY_WACK_EN: acknowledge writes as soon as
// AW and W complete, tracking the outstanding B response in a flag that
// blocks new requests until it arrives.
module sramlike_axi_bridge
  import axi_bridge_pkg::*;
#(
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input  logic        clk,
  input  logic        resetn,
  // SRAM-like side
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  // AR channel
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  // R channel
  input  logic [3:0]  rid,
  input  logic [31:0] rdata_i,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  // AW channel
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  // W channel
  output logic [3:0]  wid,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  // B channel
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  state_t      state_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        data_ok_q;
  logic        arvalid_q;
  logic        rready_q;
  logic        awvalid_q;
  logic        wvalid_q;
  logic        bready_q;
  logic        aw_done;
  logic        w_done;
  logic        can_accept;

  // Response IDs/status and rlast carry nothing this bridge acts on.
  logic unused_resp;
  assign unused_resp = &{1'b0, rid, rresp, rlast, bid, bresp};

`ifdef DBRIDGE_EARLY_WACK_EN
  logic b_pend_q;
  assign can_accept = (state_q == IDLE) && !data_ok_q && !b_pend_q;
`else
  assign can_accept = (state_q == IDLE) && !data_ok_q;
`endif

  // Address handshake back to the master; suppressed in a data_ok cycle.
  assign addr_ok = resetn && can_accept && req;

  // A channel counts as done once its valid has dropped or is handshaking now.
  always_comb begin
    aw_done = !awvalid_q || awready;
    w_done  = !wvalid_q  || wready;
  end

  assign data_ok = data_ok_q;
  assign rdata   = rdata_q;

  assign arid    = AXI_ID;
  assign araddr  = addr_q;
  assign arlen   = LEN_SINGLE;
  assign arsize  = {1'b0, size_q};
  assign arburst = BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;

  assign awid    = AXI_ID;
  assign awaddr  = addr_q;
  assign awlen   = LEN_SINGLE;
  assign awsize  = {1'b0, size_q};
  assign awburst = BURST_INCR;
  assign awlock  = 2'b00;
  assign awcache = 4'b0000;
  assign awprot  = 3'b000;
  assign awvalid = awvalid_q;

  assign wid     = AXI_ID;
  assign wdata_o = wdata_q;
  assign wstrb   = calc_wstrb(size_q, addr_q[1:0]);
  assign wlast   = 1'b1;
  assign wvalid  = wvalid_q;
  assign bready  = bready_q;

  // Transaction FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      size_q    <= 2'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      rdata_q   <= 32'd0;
      data_ok_q <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
`ifdef DBRIDGE_EARLY_WACK_EN
      b_pend_q  <= 1'b0;
`endif
    end else begin
      data_ok_q <= 1'b0;
      case (state_q)
        IDLE: begin
`ifdef DBRIDGE_EARLY_WACK_EN
          if (b_pend_q && bvalid) begin
            b_pend_q <= 1'b0;
            bready_q <= 1'b0;
          end
`endif
          if (addr_ok) begin
            size_q  <= size;
            addr_q  <= addr;
            wdata_q <= wdata;
            if (wr) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= WR_AW;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= RD_A;
            end
          end
        end
        RD_A: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RD_D;
          end
        end
        RD_D: begin
          if (rvalid) begin
            rdata_q   <= rdata_i;
            data_ok_q <= 1'b1;
            rready_q  <= 1'b0;
            state_q   <= IDLE;
          end
        end
        WR_AW: begin
          if (awvalid_q && awready) awvalid_q <= 1'b0;
          if (wvalid_q && wready)   wvalid_q  <= 1'b0;
          if (aw_done && w_done) begin
            bready_q <= 1'b1;
`ifdef DBRIDGE_EARLY_WACK_EN
            data_ok_q <= 1'b1;
            b_pend_q  <= 1'b1;
            state_q   <= IDLE;
`else
            state_q   <= WR_B;
`endif
          end
        end
        WR_B: begin
          if (bvalid) begin
            data_ok_q <= 1'b1;
            bready_q  <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
